// File: rtl/aes_selftest_seq_if.sv
// rtl/aes_selftest_seq_if.sv - request/response bus between the self-test sequencer and the AES engine
interface aes_selftest_seq_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_data;
  logic [255:0] req_key;
  logic [1:0]   req_keylen;
  logic         req_decrypt;
  logic         resp_valid;
  logic [127:0] resp_data;

  modport master (
    output req_valid, req_data, req_key, req_keylen, req_decrypt,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, req_key, req_keylen, req_decrypt,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/aes_selftest_seq.sv
// rtl/aes_selftest_seq.sv - AES built-in self-test sequencer: encrypt/decrypt round trips plus FIPS-197 known answers
module aes_selftest_seq #(
  parameter int NUM_VEC = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [1:0]          mode,
  aes_selftest_seq_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                led128,
  output logic                led192,
  output logic                led256,
  output logic [CNT_W-1:0]    fail_count,
  output logic                timeout_err
);

  typedef enum logic [2:0] {IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, NEXT, FIN} state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [127:0]    PT_BASE  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0]    KAT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0]    KAT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0]    KAT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [7:0]      LAST_VEC = 8'(NUM_VEC - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [7:0]        vec_idx;
  logic [WD_W-1:0]   wd;
  logic [127:0]      ct_reg, pt_reg;
  logic [1:0]        cur_len;
  logic              all_mode, size_fail;
  logic [127:0]      plaintext, kat;
  logic [255:0]      key;
  logic              in_wait, wd_trip, fail_evt, last_vec, more_sizes;

  assign plaintext  = PT_BASE ^ {120'b0, vec_idx};
  assign in_wait    = (state == ENC_WAIT) || (state == DEC_WAIT);
  assign wd_trip    = in_wait && !bus.resp_valid && (wd == WD_LAST);
  assign last_vec   = (vec_idx == LAST_VEC);
  // In all-sizes mode the order is 128 (len 0), 192 (len 2), 256 (len 1).
  assign more_sizes = all_mode && (cur_len != 2'd1);

  always_comb begin
    kat = KAT256;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    case (cur_len)
      2'd0: begin
        kat = KAT128;
        key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      end
      2'd2: begin
        kat = KAT192;
        key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      end
      default: ;
    endcase
  end

  assign fail_evt = ((state == ENC_WAIT) && bus.resp_valid && (vec_idx == 8'd0) && (bus.resp_data != kat))
                 || ((state == CHECK) && (pt_reg != plaintext))
                 || wd_trip;

  always_comb begin
    state_n         = state;
    bus.req_valid   = 1'b0;
    bus.req_data    = '0;
    bus.req_key     = '0;
    bus.req_keylen  = '0;
    bus.req_decrypt = 1'b0;
    busy            = (state != IDLE);
    done            = (state == FIN) && enable;
    case (state)
      IDLE:     if (start && enable) state_n = ENC_REQ;
      ENC_REQ: begin
        bus.req_valid  = 1'b1;
        bus.req_data   = plaintext;
        bus.req_key    = key;
        bus.req_keylen = cur_len;
        if (bus.req_ready) state_n = ENC_WAIT;
      end
      ENC_WAIT: begin
        if (bus.resp_valid) state_n = DEC_REQ;
        else if (wd_trip)   state_n = FIN;
      end
      DEC_REQ: begin
        bus.req_valid   = 1'b1;
        bus.req_data    = ct_reg;
        bus.req_key     = key;
        bus.req_keylen  = cur_len;
        bus.req_decrypt = 1'b1;
        if (bus.req_ready) state_n = DEC_WAIT;
      end
      DEC_WAIT: begin
        if (bus.resp_valid) state_n = CHECK;
        else if (wd_trip)   state_n = FIN;
      end
      CHECK:    state_n = NEXT;
      NEXT:     state_n = (!last_vec || more_sizes) ? ENC_REQ : FIN;
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      vec_idx     <= '0;
      wd          <= '0;
      ct_reg      <= '0;
      pt_reg      <= '0;
      cur_len     <= '0;
      all_mode    <= 1'b0;
      size_fail   <= 1'b0;
      led128      <= 1'b0;
      led192      <= 1'b0;
      led256      <= 1'b0;
      fail_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      // With enable low the run is abandoned; results stay as they were.
      if (enable) begin
        case (state)
          IDLE: if (start) begin
            fail_count  <= '0;
            timeout_err <= 1'b0;
            if (mode == 2'd0 || mode == 2'd3) led128 <= 1'b0;
            if (mode == 2'd2 || mode == 2'd3) led192 <= 1'b0;
            if (mode == 2'd1 || mode == 2'd3) led256 <= 1'b0;
            all_mode  <= (mode == 2'd3);
            cur_len   <= (mode == 2'd3) ? 2'd0 : mode;
            vec_idx   <= '0;
            size_fail <= 1'b0;
            wd        <= '0;
          end
          ENC_REQ, DEC_REQ: wd <= '0;
          ENC_WAIT, DEC_WAIT: begin
            if (bus.resp_valid) begin
              if (state == ENC_WAIT) ct_reg <= bus.resp_data;
              else                   pt_reg <= bus.resp_data;
            end else if (wd_trip) begin
              timeout_err <= 1'b1;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          NEXT: begin
            if (last_vec) begin
              case (cur_len)
                2'd0:    led128 <= !size_fail;
                2'd2:    led192 <= !size_fail;
                default: led256 <= !size_fail;
              endcase
              vec_idx   <= '0;
              size_fail <= 1'b0;
              cur_len   <= (cur_len == 2'd0) ? 2'd2 : 2'd1;
            end else begin
              vec_idx <= vec_idx + 8'd1;
            end
          end
          default: ;
        endcase
        if (fail_evt) begin
          size_fail <= 1'b1;
          if (fail_count != '1) fail_count <= fail_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_selftest_seq.sv
// tb/tb_aes_selftest_seq.sv - scoreboard bench for aes_selftest_seq with a behavioural stand-in AES engine
module tb_aes_selftest_seq;
  localparam int NUM_VEC = 4;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;
  localparam logic [127:0] PT0    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] MASK   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic busy, done, led128, led192, led256, timeout_err;
  logic [CNT_W-1:0] fail_count;

  aes_selftest_seq_if bus();

  aes_selftest_seq #(.NUM_VEC(NUM_VEC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode), .bus(bus),
    .busy(busy), .done(done), .led128(led128), .led192(led192), .led256(led256),
    .fail_count(fail_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   keylen;
    logic         decrypt;
    logic [127:0] data;
    logic [255:0] key;
  } req_t;

  typedef struct packed {
    logic             l128, l192, l256;
    logic [CNT_W-1:0] fails;
    logic             tmo;
  } res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  req_t got_req, e_req;
  res_t e_res;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cycle = 0;
  int last_hs = 0;
  int done_at = 0;
  int latency = 10;
  bit mute = 1'b0;
  bit corrupt = 1'b0;
  bit eng_pending = 1'b0;
  int eng_cnt = 0;
  logic [127:0] eng_data = '0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [127:0] kat_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return KAT128;
      2'd2:    return KAT192;
      default: return KAT256;
    endcase
  endfunction

  function automatic logic [255:0] key_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      2'd2:    return {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      default: return 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    endcase
  endfunction

  function automatic logic [127:0] mask_of(input logic [1:0] kl);
    return MASK ^ {126'b0, kl};
  endfunction

  // Stand-in cipher: vector 0 maps to the published answer, other blocks to a keyed XOR.
  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [1:0] kl);
    if (pt == PT0) return kat_of(kl) ^ {127'b0, corrupt};
    return pt ^ mask_of(kl);
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] ct, input logic [1:0] kl);
    if (ct == (kat_of(kl) ^ {127'b0, corrupt})) return PT0;
    return ct ^ mask_of(kl);
  endfunction

  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.resp_valid = 1'b0;
      if (reset) begin
        eng_pending = 1'b0;
      end else begin
        if (eng_pending) begin
          eng_cnt = eng_cnt - 1;
          if (eng_cnt == 0) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = eng_data;
            eng_pending    = 1'b0;
          end
        end
        if (bus.req_valid && bus.req_ready && !mute) begin
          eng_pending = 1'b1;
          eng_cnt     = latency;
          eng_data    = bus.req_decrypt ? dec_model(bus.req_data, bus.req_keylen)
                                        : enc_model(bus.req_data, bus.req_keylen);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready && !reset) begin
        last_hs = cycle;
        got_req = '{bus.req_keylen, bus.req_decrypt, bus.req_data, bus.req_key};
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req got keylen=%0d dec=%0b data=%h", got_req.keylen, got_req.decrypt, got_req.data);
        end else begin
          e_req = exp_req.pop_front();
          if (got_req !== e_req) begin
            errors++;
            $display("FAIL req got keylen=%0d dec=%0b data=%h key=%h want keylen=%0d dec=%0b data=%h key=%h",
                     got_req.keylen, got_req.decrypt, got_req.data, got_req.key,
                     e_req.keylen, e_req.decrypt, e_req.data, e_req.key);
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_at = cycle;
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cycle);
        end else begin
          e_res = exp_res.pop_front();
          if ({led128, led192, led256, fail_count, timeout_err} !== e_res) begin
            errors++;
            $display("FAIL result got leds=%b%b%b fails=%0d tmo=%b want leds=%b%b%b fails=%0d tmo=%b",
                     led128, led192, led256, fail_count, timeout_err,
                     e_res.l128, e_res.l192, e_res.l256, e_res.fails, e_res.tmo);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_req(input logic [1:0] kl, input logic dec, input logic [127:0] d);
    exp_req.push_back('{kl, dec, d, key_of(kl)});
  endtask

  task automatic push_size(input logic [1:0] kl);
    logic [127:0] pt, ct;
    for (int i = 0; i < NUM_VEC; i++) begin
      pt = PT0 ^ {120'b0, 8'(i)};
      ct = (i == 0) ? (kat_of(kl) ^ {127'b0, corrupt}) : (pt ^ mask_of(kl));
      push_req(kl, 1'b0, pt);
      push_req(kl, 1'b1, ct);
    end
  endtask

  task automatic push_res(input logic a, input logic b, input logic c, input int f, input logic t);
    exp_res.push_back('{a, b, c, CNT_W'(f), t});
  endtask

  task automatic wait_run(input string nm, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    repeat (20) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s done_pulses got %0d want 1", nm, done_cnt - d0);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({busy, done, led128, led192, led256, timeout_err, bus.req_valid} !== 7'b0 || fail_count !== '0) begin
      errors++;
      $display("FAIL %s outputs got busy=%b done=%b leds=%b%b%b tmo=%b req_valid=%b fails=%0d want all 0",
               nm, busy, done, led128, led192, led256, timeout_err, bus.req_valid, fail_count);
    end
  endtask

  initial begin
    int n;
    int delta;
    bus.req_ready = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // AES-128 only, ideal engine
    push_size(2'd0);
    push_res(1, 0, 0, 0, 0);
    pulse_start(2'd0);
    wait_run("mode0", 1000);

    // all three sizes in order 128, 192, 256
    push_size(2'd0);
    push_size(2'd2);
    push_size(2'd1);
    push_res(1, 1, 1, 0, 0);
    pulse_start(2'd3);
    wait_run("mode3", 3000);

    // AES-256 with a corrupted known answer that still round-trips
    corrupt = 1'b1;
    push_size(2'd1);
    push_res(1, 1, 0, 1, 0);
    pulse_start(2'd1);
    wait_run("mode1_kat", 1000);
    corrupt = 1'b0;

    // AES-192 with a silent engine: watchdog ends the run
    mute = 1'b1;
    push_req(2'd2, 1'b0, PT0);
    push_res(1, 0, 0, 1, 1);
    pulse_start(2'd2);
    wait_run("mode2_timeout", 500);
    mute = 1'b0;
    delta = done_at - last_hs - 1;
    checks++;
    if (delta < TIMEOUT - 1 || delta > TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d+-1", delta, TIMEOUT);
    end

    // engine stalls the first request for 20 cycles
    bus.req_ready = 1'b0;
    push_size(2'd0);
    push_res(1, 0, 0, 0, 0);
    pulse_start(2'd0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus.req_valid !== 1'b1 || bus.req_data !== PT0 || bus.req_key !== key_of(2'd0)
          || bus.req_keylen !== 2'd0 || bus.req_decrypt !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b data=%h keylen=%0d dec=%b want valid=1 data=%h keylen=0 dec=0",
                 i, bus.req_valid, bus.req_data, bus.req_keylen, bus.req_decrypt, PT0);
      end
      tick();
    end
    bus.req_ready = 1'b1;
    wait_run("stall", 1000);

    // reset while waiting for the decrypt response
    push_req(2'd0, 1'b0, PT0);
    push_req(2'd0, 1'b1, KAT128);
    pulse_start(2'd0);
    n = 0;
    while (exp_req.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_req.size() != 0) begin
      errors++;
      $display("FAIL dec_handshake_wait got %0d pending want 0", exp_req.size());
    end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_zero("mid_reset");
    reset = 1'b0;
    tick();

    // a second start while busy is ignored
    push_size(2'd0);
    push_res(1, 0, 0, 0, 0);
    pulse_start(2'd0);
    repeat (5) tick();
    pulse_start(2'd0);
    wait_run("restart", 1000);
    repeat (100) tick();

    checks++;
    if (exp_req.size() != 0 || exp_res.size() != 0) begin
      errors++;
      $display("FAIL leftover got req=%0d res=%0d want 0 0", exp_req.size(), exp_res.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_selftest_seq.md
Name: aes_selftest_seq

Overview:
- Parametrised built-in self-test sequencer for the AES datapath.
- Drives one shared cipher/inverse-cipher engine through a valid/ready request and valid response interface.
- Each vector runs encrypt, then decrypt. Checks the round trip and, on vector 0, the FIPS-197 known-answer ciphertext.
- Covers AES-128, AES-192 and AES-256. Keeps per-mode pass flags, a fail counter and a timeout watchdog; sits between board LEDs and the AES cores.

Parameters:
- NUM_VEC, 4, vectors per key size (1..255).
- TIMEOUT, 64, max cycles waiting for resp_valid per request (>=2).
- CNT_W, 8, width of fail_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  gate; low aborts the run like reset, but leaves results intact.
- start  in  1  one-cycle pulse; begins a run when idle.
- mode  in  2  0=AES-128, 1=AES-256, 2=AES-192, 3=all three in order 128, 192, 256; sampled at start.
- req_valid  out  1  request to engine.
- req_ready  in  1  engine accepts request.
- req_data  out  128  block to process.
- req_key  out  256  key, left-aligned; unused low bits zero.
- req_keylen  out  2  0=128, 1=256, 2=192.
- req_decrypt  out  1  1=inverse cipher.
- resp_valid  in  1  result valid, one cycle.
- resp_data  in  128  result.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end (normal or timeout).
- led128 / led192 / led256  out  1 each  that key size fully passed in last run.
- fail_count  out  CNT_W  failed checks in last run, saturating.
- timeout_err  out  1  last run ended by watchdog.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, vector index 0, watchdog 0.
- Vector i plaintext: 128'h00112233445566778899aabbccddeeff XOR {120'b0, i[7:0]}.
- Keys (FIPS-197):
  - 128: 000102..0f.
  - 192: 000102..17.
  - 256: 000102..1f.
- Known-answer ciphertexts for i=0:
  - 128 -> 69c4e0d86a7b0430d8cdb78070b4c55a.
  - 192 -> dda97ca4864cdfe06eaf70a0ec0d7191.
  - 256 -> 8ea2b7ca516745bfeafc49904b496089.
- FSM states: IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, NEXT, FIN.
- IDLE: on start && enable:
  - Clear fail_count, timeout_err, and the leds selected by mode; other leds keep their value.
  - Latch mode, set busy, go to ENC_REQ the next cycle.
  - start while busy is ignored.
- ENC_REQ / DEC_REQ:
  - req_valid=1 with stable fields until the cycle req_ready=1; the handshake completes in that cycle.
  - Then go to the matching WAIT state with watchdog cleared.
  - req_valid drops the cycle after the handshake.
- ENC_WAIT:
  - On resp_valid, capture ct; if i==0 and ct != KAT, fail_count+1.
  - Go to DEC_REQ with req_data=ct, req_decrypt=1.
- DEC_WAIT: on resp_valid, capture pt and go to CHECK.
- CHECK: if pt != plaintext_i, fail_count+1. Takes one cycle.
- NEXT: i+1. When i==NUM_VEC-1:
  - Set the current size's led iff this size logged zero fails.
  - Advance to the next size (mode 3) or go to FIN.
- FIN: pulse done for one cycle, clear busy, return to IDLE.
- Watchdog: counts cycles in each WAIT state. At TIMEOUT with no resp_valid:
  - Set timeout_err, fail_count+1, abandon the run (no led set for the current size), go to FIN.
- resp_valid outside a WAIT state is ignored.
- fail_count saturates at 2^CNT_W-1.
- Minimum per-vector latency: 2 handshakes + engine latency ×2 + 2 cycles (CHECK, NEXT).
- enable low mid-run:
  - Go to IDLE next cycle, req_valid=0, busy=0, no done pulse.
  - leds and fail_count keep their partial values.
- reset mid-run: full reset as above, including leds.

Test Plan:
- mode=0, ideal engine (ready=1, 10-cycle latency), NUM_VEC=4 -> 8 handshakes, ct0=69c4e0d8..c55a, done pulse, led128=1, fail_count=0.
- mode=3, ideal engine -> sizes run in order 128, 192, 256 (req_keylen 0, 2, 1); led128=led192=led256=1; exactly one done pulse.
- mode=1, engine corrupts ct of vector 0 bit 0 and its inverse -> KAT fail +1, round trip passes; fail_count=1, led256=0.
- mode=2, engine never raises resp_valid, TIMEOUT=64 -> done 64 cycles after the first handshake (±1), timeout_err=1, fail_count=1, led192=0.
- req_ready held low 20 cycles -> req_valid and all req fields stable throughout; no watchdog trip.
- Reset asserted mid DEC_WAIT, then start pulsed while busy in a new run -> outputs zero after reset; the second start is ignored, one done pulse per run.
